// File: rtl/clock_step_pkg.sv
// Shared types for the core clock step controller: FSM states and the
// same-cycle command priority encoder.
package clock_step_pkg;

   typedef enum logic [1:0] {
      StHalt  = 2'd0,
      StRun   = 2'd1,
      StStep  = 2'd2,
      StBurst = 2'd3
   } state_t;

   // Enumerated in decreasing priority after reset.
   typedef enum logic [2:0] {
      CmdNone  = 3'd0,
      CmdHalt  = 3'd1,
      CmdRun   = 3'd2,
      CmdBurst = 3'd3,
      CmdStep  = 3'd4
   } cmd_t;

   function automatic cmd_t pick_cmd(input logic halt, input logic run,
                                     input logic burst, input logic step);
      cmd_t c;
      if (halt)       c = CmdHalt;
      else if (run)   c = CmdRun;
      else if (burst) c = CmdBurst;
      else if (step)  c = CmdStep;
      else            c = CmdNone;
      return c;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider counter with a runtime-loadable divisor; tick marks the
// last board cycle of each divisor period.
module tick_divider #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DIV_DEFAULT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             tick
);

   localparam logic [CNT_W-1:0] DivRst = (DIV_DEFAULT == 0) ? CNT_W'(1) : CNT_W'(DIV_DEFAULT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;

   assign tick = (cnt_q == div_q - CNT_W'(1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      div_d = div_q;
      if (div_load) begin
         // A zero divisor would never tick; treat it as the fastest rate.
         div_d = (div_in == '0) ? CNT_W'(1) : div_in;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         div_q <= DivRst;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/clock_step_controller.sv
// Core clock generator with run/halt/step/burst control: divided clock, ce
// pulse on each rising edge, retired-cycle counter and heartbeat led.
module clock_step_controller
   import clock_step_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DIV_DEFAULT = 2,
   parameter int unsigned BURST_W     = 16,
   parameter int unsigned CYC_W       = 32,
   parameter int unsigned LED_DIV     = 1,
   parameter bit          START_RUN   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CNT_W-1:0]   div_in,
   input  logic               div_load,
   input  logic               cmd_run,
   input  logic               cmd_halt,
   input  logic               cmd_step,
   input  logic               cmd_burst,
   input  logic [BURST_W-1:0] burst_len,
   output logic               clk_out,
   output logic               ce,
   output logic               led,
   output logic               busy,
   output logic [1:0]         state_o,
   output logic [CYC_W-1:0]   cycle_count,
   output logic [BURST_W-1:0] burst_rem
);

   localparam int unsigned LedW = $clog2(LED_DIV) + 1;
   localparam state_t      StReset = START_RUN ? StRun : StHalt;

   state_t             state_q, state_d;
   logic               clk_out_q, clk_out_d;
   logic               ce_q, ce_d;
   logic               led_q, led_d;
   logic [LedW-1:0]    led_cnt_q, led_cnt_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               pend_q, pend_d;
   logic               tick, rise, fall, halting, park;
   cmd_t               cmd;

   tick_divider #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) u_tick_divider (
      .clk      (clk),
      .reset    (reset),
      .div_in   (div_in),
      .div_load (div_load),
      .tick     (tick)
   );

   always_comb begin
      state_d   = state_q;
      clk_out_d = clk_out_q;
      ce_d      = 1'b0;
      led_d     = led_q;
      led_cnt_d = led_cnt_q;
      cyc_d     = cyc_q;
      rem_d     = rem_q;
      pend_d    = pend_q;
      rise      = 1'b0;
      fall      = 1'b0;
      cmd       = pick_cmd(cmd_halt, cmd_run, cmd_burst, cmd_step);
      halting   = pend_q | (cmd == CmdHalt);

      // A pending halt suppresses rising edges so clk_out only ever parks low.
      if (state_q != StHalt && tick) begin
         if (clk_out_q)     fall = 1'b1;
         else if (!halting) rise = 1'b1;
      end
      park = halting && (fall || !clk_out_q);

      if (rise) begin
         clk_out_d = 1'b1;
         ce_d      = 1'b1;
         cyc_d     = cyc_q + CYC_W'(1);
         if (state_q == StBurst) rem_d = rem_q - BURST_W'(1);
         if (led_cnt_q == LedW'(LED_DIV - 1)) begin
            led_cnt_d = '0;
            led_d     = ~led_q;
         end else begin
            led_cnt_d = led_cnt_q + LedW'(1);
         end
      end
      if (fall) clk_out_d = 1'b0;

      unique case (state_q)
         StHalt:  state_d = StHalt;
         StRun:   if (park) state_d = StHalt;
         StStep:  if (fall || park) state_d = StHalt;
         StBurst: if ((fall && rem_q == '0) || park) state_d = StHalt;
         default: state_d = StHalt;
      endcase

      unique case (cmd)
         CmdHalt: begin
            if (state_q != StHalt) begin
               pend_d = 1'b1;
               rem_d  = '0;
            end
         end
         CmdRun: begin
            state_d = StRun;
            pend_d  = 1'b0;
         end
         CmdBurst: begin
            if (state_q == StHalt && burst_len != '0) begin
               rem_d   = burst_len;
               state_d = StBurst;
            end
         end
         CmdStep: if (state_q == StHalt) state_d = StStep;
         default: ;
      endcase

      if (state_d == StHalt) pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StReset;
         clk_out_q <= 1'b0;
         ce_q      <= 1'b0;
         led_q     <= 1'b0;
         led_cnt_q <= '0;
         cyc_q     <= '0;
         rem_q     <= '0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_out_q <= clk_out_d;
         ce_q      <= ce_d;
         led_q     <= led_d;
         led_cnt_q <= led_cnt_d;
         cyc_q     <= cyc_d;
         rem_q     <= rem_d;
         pend_q    <= pend_d;
      end
   end

   assign clk_out     = clk_out_q;
   assign ce          = ce_q;
   assign led         = led_q;
   assign busy        = (state_q == StStep) || (state_q == StBurst);
   assign state_o     = state_q;
   assign cycle_count = cyc_q;
   assign burst_rem   = rem_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller with default parameters; inputs are
// driven and outputs sampled on the falling board clock edge.
module tb_clock_step_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] div_in = '0;
   logic        div_load = 1'b0;
   logic        cmd_run = 1'b0;
   logic        cmd_halt = 1'b0;
   logic        cmd_step = 1'b0;
   logic        cmd_burst = 1'b0;
   logic [15:0] burst_len = '0;
   logic        clk_out, ce, led, busy;
   logic [1:0]  state_o;
   logic [31:0] cycle_count;
   logic [15:0] burst_rem;

   int vectors = 0;
   int miscompares = 0;

   clock_step_controller #(
      .CNT_W       (32),
      .DIV_DEFAULT (2),
      .BURST_W     (16),
      .CYC_W       (32),
      .LED_DIV     (1),
      .START_RUN   (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .div_in      (div_in),
      .div_load    (div_load),
      .cmd_run     (cmd_run),
      .cmd_halt    (cmd_halt),
      .cmd_step    (cmd_step),
      .cmd_burst   (cmd_burst),
      .burst_len   (burst_len),
      .clk_out     (clk_out),
      .ce          (ce),
      .led         (led),
      .busy        (busy),
      .state_o     (state_o),
      .cycle_count (cycle_count),
      .burst_rem   (burst_rem)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Leaves reset asserted at a falling edge; caller releases it.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_burst = 0;
      div_load = 0; div_in = '0; burst_len = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({clk_out, ce, led, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_bits: got %b want 0000", {clk_out, ce, led, busy});
      end
      vectors++;
      if (cycle_count !== 32'd0 || burst_rem !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_counts: got cyc=%0d rem=%0d want 0/0", cycle_count, burst_rem);
      end
      vectors++;
      if (state_o !== 2'd1) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want 1", state_o);
      end
   endtask

   task automatic test_run_default();
      logic exp_clk, exp_ce;
      do_reset();
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         exp_clk = (k % 4 == 2) || (k % 4 == 3);
         exp_ce  = (k % 4 == 2);
         vectors++;
         if (clk_out !== exp_clk || ce !== exp_ce) begin
            miscompares++;
            $display("FAIL run_wave k=%0d: got clk_out=%b ce=%b want %b %b",
                     k, clk_out, ce, exp_clk, exp_ce);
         end
         if (k == 2) begin
            vectors++;
            if (led !== 1'b1) begin
               miscompares++;
               $display("FAIL run_led_first: got %b want 1", led);
            end
         end
      end
      vectors++;
      if (cycle_count !== 32'd10 || led !== 1'b0) begin
         miscompares++;
         $display("FAIL run_count: got cyc=%0d led=%b want 10 0", cycle_count, led);
      end
   endtask

   task automatic test_div_zero();
      logic exp_v;
      do_reset();
      reset = 1'b0; div_load = 1'b1; div_in = 32'd0;
      @(negedge clk);
      div_load = 1'b0; cmd_run = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         @(negedge clk);
         cmd_run = 1'b0;
         exp_v = (k % 2 == 0);
         vectors++;
         if (clk_out !== exp_v || ce !== exp_v) begin
            miscompares++;
            $display("FAIL div0_wave k=%0d: got clk_out=%b ce=%b want %b %b",
                     k, clk_out, ce, exp_v, exp_v);
         end
      end
      vectors++;
      if (cycle_count !== 32'd4) begin
         miscompares++;
         $display("FAIL div0_count: got %0d want 4", cycle_count);
      end
   endtask

   task automatic test_step();
      logic exp_clk, exp_ce, exp_busy;
      logic [1:0] exp_st;
      do_reset();
      reset = 1'b0; cmd_halt = 1'b1;
      @(negedge clk);
      cmd_halt = 1'b0;
      vectors++;
      if (state_o !== 2'd0) begin
         miscompares++;
         $display("FAIL step_pre_halt: got state %0d want 0", state_o);
      end
      cmd_step = 1'b1;
      @(negedge clk);
      cmd_step = 1'b0;
      vectors++;
      if (state_o !== 2'd2 || busy !== 1'b1 || clk_out !== 1'b0) begin
         miscompares++;
         $display("FAIL step_enter: got state=%0d busy=%b clk_out=%b want 2 1 0",
                  state_o, busy, clk_out);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_clk  = (i == 1) || (i == 2);
         exp_ce   = (i == 1);
         exp_busy = (i < 3);
         exp_st   = (i < 3) ? 2'd2 : 2'd0;
         vectors++;
         if (clk_out !== exp_clk || ce !== exp_ce || busy !== exp_busy || state_o !== exp_st) begin
            miscompares++;
            $display("FAIL step_seq i=%0d: got clk=%b ce=%b busy=%b st=%0d want %b %b %b %0d",
                     i, clk_out, ce, busy, state_o, exp_clk, exp_ce, exp_busy, exp_st);
         end
      end
      vectors++;
      if (cycle_count !== 32'd1) begin
         miscompares++;
         $display("FAIL step_count: got %0d want 1", cycle_count);
      end
   endtask

   task automatic start_burst3x5();
      do_reset();
      reset = 1'b0; cmd_halt = 1'b1; div_load = 1'b1; div_in = 32'd3;
      @(negedge clk);
      cmd_halt = 1'b0; div_load = 1'b0; cmd_burst = 1'b1; burst_len = 16'd5;
      @(negedge clk);
      cmd_burst = 1'b0;
   endtask

   task automatic test_burst();
      int n_ce = 0;
      int prev = 0;
      start_burst3x5();
      vectors++;
      if (state_o !== 2'd3 || burst_rem !== 16'd5 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_enter: got st=%0d rem=%0d busy=%b want 3 5 1",
                  state_o, burst_rem, busy);
      end
      for (int n = 3; n <= 40; n++) begin
         @(negedge clk);
         if (ce === 1'b1) begin
            n_ce++;
            vectors++;
            if ((prev == 0 && n != 4) || (prev != 0 && n - prev != 6)) begin
               miscompares++;
               $display("FAIL burst_spacing: ce at clk %0d, previous %0d, want 4 then +6", n, prev);
            end
            prev = n;
         end
         if (n == 30 || n == 31) begin
            vectors++;
            if (state_o !== ((n == 30) ? 2'd3 : 2'd0)) begin
               miscompares++;
               $display("FAIL burst_exit n=%0d: got state %0d want %0d",
                        n, state_o, (n == 30) ? 3 : 0);
            end
         end
      end
      vectors++;
      if (n_ce != 5 || burst_rem !== 16'd0 || clk_out !== 1'b0 || cycle_count !== 32'd5) begin
         miscompares++;
         $display("FAIL burst_total: got ce=%0d rem=%0d clk=%b cyc=%0d want 5 0 0 5",
                  n_ce, burst_rem, clk_out, cycle_count);
      end
      cmd_burst = 1'b1; burst_len = 16'd0;
      @(negedge clk);
      cmd_burst = 1'b0;
      n_ce = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ce === 1'b1) n_ce++;
      end
      vectors++;
      if (state_o !== 2'd0 || n_ce != 0) begin
         miscompares++;
         $display("FAIL burst_zero: got state=%0d ce=%0d want 0 0", state_o, n_ce);
      end
   endtask

   task automatic test_halt();
      int n_ce = 0;
      int n_hi = 0;
      do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (clk_out !== 1'b1) begin
         miscompares++;
         $display("FAIL halt_pre: got clk_out %b want 1", clk_out);
      end
      cmd_halt = 1'b1;
      @(negedge clk);
      cmd_halt = 1'b0;
      vectors++;
      if (clk_out !== 1'b1 || state_o !== 2'd1) begin
         miscompares++;
         $display("FAIL halt_hold_high: got clk=%b st=%0d want 1 1", clk_out, state_o);
      end
      @(negedge clk);
      vectors++;
      if (clk_out !== 1'b0 || state_o !== 2'd0) begin
         miscompares++;
         $display("FAIL halt_park: got clk=%b st=%0d want 0 0", clk_out, state_o);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ce === 1'b1) n_ce++;
         if (clk_out === 1'b1) n_hi++;
      end
      vectors++;
      if (n_ce != 0 || n_hi != 0 || cycle_count !== 32'd1) begin
         miscompares++;
         $display("FAIL halt_quiet: got ce=%0d high=%0d cyc=%0d want 0 0 1",
                  n_ce, n_hi, cycle_count);
      end
      do_reset();
      reset = 1'b0; cmd_halt = 1'b1; cmd_run = 1'b1;
      @(negedge clk);
      cmd_halt = 1'b0; cmd_run = 1'b0;
      n_ce = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ce === 1'b1) n_ce++;
      end
      vectors++;
      if (state_o !== 2'd0 || n_ce != 0) begin
         miscompares++;
         $display("FAIL halt_vs_run: got state=%0d ce=%0d want 0 0", state_o, n_ce);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit found = 0;
      int n_ce = 0;
      start_burst3x5();
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (burst_rem === 16'd3) found = 1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL midburst_wait: got no burst_rem==3 within 60 clks, want it");
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({clk_out, ce, led, busy} !== 4'b0000 || cycle_count !== 32'd0 ||
          burst_rem !== 16'd0 || state_o !== 2'd1) begin
         miscompares++;
         $display("FAIL midburst_reset: got clk=%b ce=%b led=%b busy=%b cyc=%0d rem=%0d st=%0d want 0 0 0 0 0 0 1",
                  clk_out, ce, led, busy, cycle_count, burst_rem, state_o);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ce === 1'b1) n_ce++;
      end
      vectors++;
      if (n_ce != 0 || cycle_count !== 32'd0) begin
         miscompares++;
         $display("FAIL midburst_no_ce: got ce=%0d cyc=%0d want 0 0", n_ce, cycle_count);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_default();
      test_div_zero();
      test_step();
      test_burst();
      test_halt();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clock_step_controller.md
Name: clock_step_controller

Overview:
Parametrised successor to the fixed free-running core clock divider. It generates the divided core clock (clk_out), a one-cycle core clock-enable pulse (ce) and a heartbeat LED, all from the board clock. It adds a runtime-loadable divisor and run/halt/single-step/burst control, so the pipeline can be debugged on the FPGA. It sits at top level between the board clock and every pipeline module; the memory stays on the board clock.

Parameters:
CNT_W, 32, divider counter and divisor width
DIV_DEFAULT, 2, divisor after reset; board clocks per clk_out half-period
BURST_W, 16, burst length width
CYC_W, 32, retired core-cycle counter width
LED_DIV, 1, number of ce pulses per led toggle
START_RUN, 1, 1: enter RUN at reset; 0: enter HALT at reset

Ports:
clk  in  1  board clock; the only clock
reset  in  1  synchronous, active-high reset
div_in  in  CNT_W  new divisor value
div_load  in  1  load div_in this cycle
cmd_run  in  1  pulse: free-run
cmd_halt  in  1  pulse: halt (also driven by the CPU sleep flag)
cmd_step  in  1  pulse: one core cycle
cmd_burst  in  1  pulse: burst_len core cycles
burst_len  in  BURST_W  burst length, sampled on cmd_burst
clk_out  out  1  divided core clock; 50 % duty
ce  out  1  one board-cycle pulse, coincident with the clk_out 0->1 edge
led  out  1  heartbeat
busy  out  1  state is STEP or BURST
state_o  out  2  current state
cycle_count  out  CYC_W  number of ce pulses; wraps
burst_rem  out  BURST_W  rising edges still owed in BURST

Behaviour:
- Reset (synchronous, active-high): counter=0; div_q=DIV_DEFAULT; clk_out=0; ce=0; led=0; cycle_count=0; burst_rem=0; halt_pend=0; state=RUN if START_RUN, else HALT. Reset mid-burst or mid-step aborts the burst or step with no ce pulse.
- Divisor: div_q takes div_in on div_load; a value of 0 is stored as 1. A load also clears the counter in the same cycle. The new divisor applies from the next cycle.
- Tick: the counter increments each cycle. When counter==div_q-1, tick=1 and the counter returns to 0. In HALT the counter still runs, so the tick phase is continuous.
- An "edge" means toggling clk_out on a tick. A 0->1 edge asserts ce (registered) for exactly one cycle and increments cycle_count.
- States (enum): HALT=0, RUN=1, STEP=2, BURST=3.
- HALT: clk_out is held at 0 and there are no edges.
- RUN: an edge occurs on every tick.
- STEP: edges occur on ticks. After the 1->0 edge that follows one rising edge, the state goes to HALT.
- BURST: burst_rem is decremented on each rising edge. After the 1->0 edge with burst_rem==0, the state goes to HALT.
- Command priority (same-cycle): reset > cmd_halt > cmd_run > cmd_burst > cmd_step.
- cmd_halt in RUN/STEP/BURST: sets halt_pend. If clk_out=0, the state goes to HALT immediately. Otherwise the pending 1->0 edge completes first, then HALT. clk_out always parks low and no partial period is ever produced. burst_rem is cleared.
- cmd_run from any state: RUN. halt_pend is cleared.
- cmd_burst is accepted only in HALT. burst_len=0 is a no-op (stays HALT). Otherwise burst_rem=burst_len and the state goes to BURST.
- cmd_step is accepted only in HALT.
- Commands arriving in STEP/BURST other than halt/run are ignored.
- led toggles on every LED_DIV-th ce pulse (internal counter of width clog2(LED_DIV)+1).
- Latency: a command is registered; it affects state the next cycle, and the first ce comes at the next qualifying tick.
- cycle_count wraps from all-ones to 0 without a flag.

Decomposition:
- clock_step_pkg: state_t enum (HALT, RUN, STEP, BURST) and the command priority constants.
- One sub-module, tick_divider: holds the counter and div_q, handles div_load and the zero-to-one clamp, and outputs tick.
- The FSM, edge generation, counters and led live in clock_step_controller.

Test Plan:
- Reset release, START_RUN=1, DIV_DEFAULT=2 -> clk_out rises at the 2nd clk edge after reset, period 4 clks; ce high 1 clk every 4; cycle_count=10 after 40 clks.
- Load div_in=0 then cmd_run -> behaves as divisor 1: clk_out toggles every clk, ce every 2 clks.
- HALT, cmd_step -> exactly one ce, clk_out one high period then 0, busy high throughout, state returns to 0.
- HALT, cmd_burst with burst_len=5, divisor 3 -> exactly 5 ce pulses 6 clks apart, then HALT; a burst_len=0 request gives no ce and state stays 0.
- RUN, cmd_halt while clk_out=1 -> clk_out completes its high phase, falls, then stays 0; no further ce. Simultaneous cmd_halt+cmd_run -> HALT wins.
- Reset asserted mid-burst (burst_rem=3) -> next cycle: all outputs at their reset values, and no ce for the remaining edges.
